proc_fetch_unit: RTL and testbench
==================================

// Module: proc_fetch_unit
//
// PURPOSE
// - F stage plus F/D pipeline register of the 5-stage TinyRV1 pipeline.
// - Sits directly upstream of the pipeline control unit.
// - Holds PC_F and drives the instruction memory request.
// - Latches the fetched instruction and its PC into the D stage; the D-stage word is the
//   d2c_inst status word consumed by control.
// - Honours control's stall, redirect (pc_sel) and squash commands.
// - Keeps fetch/squash performance counters.
//
// PARAMETERS
// - RESET_PC  32'h0000_0200  PC_F value after reset (first fetch address)
// - BUBBLE    32'h0000_0000  encoding injected into D for bubbles; control treats it as invalid
//
// PORTS
// - clk                clock; all state on rising edge
// - rst                reset: synchronous, active-high
// - c2d_imemreq_val_F  in   1   control requests a fetch this cycle
// - c2d_reg_en_F       in   1   PC_F update enable; 0 = F stall
// - c2d_pc_sel_F       in   2   next-PC select: 0 pc+4, 1 jal_targ_D, 2 jr_targ_D, 3 br_targ_X
// - c2d_reg_en_D       in   1   F/D register enable; 0 = D stall
// - c2d_squash_D       in   1   replace D contents with BUBBLE
// - jal_targ_D         in   32  JAL target computed in D
// - jr_targ_D          in   32  JR target (bypassed rs1) from D
// - br_targ_X          in   32  taken-BNE target from X
// - imemreq_val        out  1   instruction memory read strobe
// - imemreq_addr       out  32  instruction memory word address (byte address, [1:0]=0)
// - imemresp_data      in   32  combinational read data for imemreq_addr, same cycle
// - d2c_inst           out  32  instruction in D (inst_D)
// - pc_D               out  32  PC of the instruction in D
// - fetch_count        out  32  instructions accepted into D since reset
// - squash_count       out  32  valid D instructions squashed since reset
//
// BEHAVIOUR
// - Reset state:
//   - pc_F = RESET_PC; d2c_inst = BUBBLE; pc_D = 0; both counters = 0.
//   - imemreq_val = 0 while rst = 1.
// - Memory request:
//   - imemreq_addr = pc_F, combinational.
//   - imemreq_val = c2d_imemreq_val_F & ~rst.
//   - Memory is a 0-latency read; data is sampled the same cycle.
// - pc_next is a 4:1 mux on c2d_pc_sel_F. pc+4 is a 32-bit add that wraps modulo 2^32.
// - PC_F update:
//   - pc_F <= pc_next when c2d_reg_en_F = 1 OR c2d_pc_sel_F = 3.
//   - A branch redirect from X overrides an F stall.
//   - Otherwise pc_F holds.
// - Target alignment: targets with addr[1:0] != 0 are written as given; alignment is the
//   datapath's responsibility.
// - F/D register (inst_D, pc_D) update, evaluated in priority order:
//   1. rst -> reset values.
//   2. c2d_squash_D -> inst_D <= BUBBLE, pc_D holds. Squash wins over a D stall.
//   3. c2d_reg_en_D = 0 -> hold both.
//   4. Otherwise, if imemreq_val = 1 -> inst_D <= imemresp_data, pc_D <= pc_F.
//      If imemreq_val = 0 -> inst_D <= BUBBLE, pc_D <= pc_F.
// - Latency: the instruction at address A, fetched in cycle t, is visible on d2c_inst in
//   cycle t+1.
// - Stall: while c2d_reg_en_F = c2d_reg_en_D = 0, the same pc_F is re-presented every cycle.
//   No instruction is lost or duplicated on release.
// - fetch_count += 1 in any cycle where case 4 loads with imemreq_val = 1 and
//   imemresp_data != BUBBLE.
// - squash_count += 1 in any cycle where c2d_squash_D = 1 and the current inst_D != BUBBLE.
// - Both counters wrap modulo 2^32 and update in the same cycle as the event.
// - Simultaneous events:
//   - Squash plus redirect (pc_sel 1/2/3) in the same cycle: D gets a bubble and
//     pc_F <= target.
//   - The next cycle's fetch is from the target.
// - Reset mid-operation (rst asserted on any cycle): next state is the reset state.
//   Counters clear. Any in-flight D instruction is discarded.
//
// TESTING
// - Reset then 4 cycles, req_val=1, pc_sel=0, no stall:
//   - imemreq_addr = 0x200, 0x204, 0x208, 0x20C.
//   - d2c_inst lags one cycle.
//   - fetch_count = 3 in cycle 4.
// - Stall 2 cycles at pc_F=0x208 (reg_en_F=reg_en_D=0):
//   - imemreq_addr stays 0x208; d2c_inst/pc_D hold the 0x204 instruction.
//   - On release, D gets the 0x208 instruction exactly once.
// - Branch: pc_sel=3, br_targ_X=0x300, squash_D=1, with reg_en_F=0:
//   - Next cycle pc_F = 0x300, d2c_inst = 0, squash_count += 1.
// - JAL in D: pc_sel=1, jal_targ_D=0x240, squash_D=0, reg_en=1:
//   - D takes the pc_F instruction; next fetch addr = 0x240.
// - Wrap: force pc_F=0xFFFF_FFFC with pc_sel=0 -> next imemreq_addr = 0x0000_0000.
//   - Also: req_val=0 -> d2c_inst = 0, fetch_count unchanged.
// - Assert rst for 1 cycle mid-stream with squash_D=1 and redirect active:
//   - Outputs return to reset values.
//   - First post-reset fetch addr = 0x200.

Source files
------------

// File: rtl/proc_fetch_unit.sv
// proc_fetch_unit: TinyRV1 F stage and F/D pipeline register with fetch/squash counters
module proc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200,
  parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c2d_imemreq_val_F,
  input  logic        c2d_reg_en_F,
  input  logic [1:0]  c2d_pc_sel_F,
  input  logic        c2d_reg_en_D,
  input  logic        c2d_squash_D,
  input  logic [31:0] jal_targ_D,
  input  logic [31:0] jr_targ_D,
  input  logic [31:0] br_targ_X,
  output logic        imemreq_val,
  output logic [31:0] imemreq_addr,
  input  logic [31:0] imemresp_data,
  output logic [31:0] d2c_inst,
  output logic [31:0] pc_D,
  output logic [31:0] fetch_count,
  output logic [31:0] squash_count
);
  logic [31:0] r_pc_f, r_inst_d, r_pc_d, r_fetch_count, r_squash_count;
  logic [31:0] w_pc_next;
  logic        w_load_d;
  // next-PC mux: sequential, JAL, JR or taken branch
  always_comb begin
    w_pc_next = c2d_pc_sel_F == 2'd0 ? r_pc_f + 32'd4 :
                c2d_pc_sel_F == 2'd1 ? jal_targ_D :
                c2d_pc_sel_F == 2'd2 ? jr_targ_D : br_targ_X;
  end
  assign imemreq_val  = c2d_imemreq_val_F & ~rst;
  assign imemreq_addr = r_pc_f;
  assign w_load_d     = ~c2d_squash_D & c2d_reg_en_D;
  assign d2c_inst     = r_inst_d;
  assign pc_D         = r_pc_d;
  assign fetch_count  = r_fetch_count;
  assign squash_count = r_squash_count;
  // PC_F, F/D register and counters; squash beats D stall, X branch beats F stall
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_f         <= RESET_PC;
      r_inst_d       <= BUBBLE;
      r_pc_d         <= 32'd0;
      r_fetch_count  <= 32'd0;
      r_squash_count <= 32'd0;
    end else begin
      if (c2d_reg_en_F || c2d_pc_sel_F == 2'd3) r_pc_f <= w_pc_next;
      if (c2d_squash_D) begin
        r_inst_d <= BUBBLE;
        if (r_inst_d != BUBBLE) r_squash_count <= r_squash_count + 32'd1;
      end else if (w_load_d) begin
        r_inst_d <= imemreq_val ? imemresp_data : BUBBLE;
        r_pc_d   <= r_pc_f;
        if (imemreq_val && imemresp_data != BUBBLE) r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_proc_fetch_unit.sv
// tb_proc_fetch_unit: directed tests of the fetch unit against hand-computed values
module tb_proc_fetch_unit;
  logic        clk = 0;
  logic        rst = 1;
  logic        req_val = 1, reg_en_f = 1, reg_en_d = 1, squash = 0, mem_zero = 0;
  logic [1:0]  pc_sel = 0;
  logic [31:0] jal_t = 0, jr_t = 0, br_t = 0;
  logic        imemreq_val;
  logic [31:0] imemreq_addr, imemresp_data, d2c_inst, pc_d, fetch_count, squash_count;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;
  assign imemresp_data = mem_zero ? 32'd0 : ~imemreq_addr;

  proc_fetch_unit dut (
    .clk(clk), .rst(rst),
    .c2d_imemreq_val_F(req_val), .c2d_reg_en_F(reg_en_f), .c2d_pc_sel_F(pc_sel),
    .c2d_reg_en_D(reg_en_d), .c2d_squash_D(squash),
    .jal_targ_D(jal_t), .jr_targ_D(jr_t), .br_targ_X(br_t),
    .imemreq_val(imemreq_val), .imemreq_addr(imemreq_addr), .imemresp_data(imemresp_data),
    .d2c_inst(d2c_inst), .pc_D(pc_d), .fetch_count(fetch_count), .squash_count(squash_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; req_val = 1;
    tick(); tick();
    checks += 6;
    if (imemreq_val !== 1'b0) begin errors++; $display("FAIL reset_val: got %b exp 0", imemreq_val); end
    if (imemreq_addr !== 32'h200) begin errors++; $display("FAIL reset_addr: got %h exp 00000200", imemreq_addr); end
    if (d2c_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h exp 0", d2c_inst); end
    if (pc_d !== 32'h0) begin errors++; $display("FAIL reset_pcd: got %h exp 0", pc_d); end
    if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_fcnt: got %0d exp 0", fetch_count); end
    if (squash_count !== 32'h0) begin errors++; $display("FAIL reset_scnt: got %0d exp 0", squash_count); end
    rst = 0;
    #1;
    checks++;
    if (imemreq_val !== 1'b1) begin errors++; $display("FAIL req_val_after_reset: got %b exp 1", imemreq_val); end
  endtask

  task automatic test_sequential();
    tick();
    checks += 4;
    if (imemreq_addr !== 32'h204) begin errors++; $display("FAIL seq1_addr: got %h exp 00000204", imemreq_addr); end
    if (d2c_inst !== ~32'h200) begin errors++; $display("FAIL seq1_inst: got %h exp %h", d2c_inst, ~32'h200); end
    if (pc_d !== 32'h200) begin errors++; $display("FAIL seq1_pcd: got %h exp 00000200", pc_d); end
    if (fetch_count !== 32'd1) begin errors++; $display("FAIL seq1_fcnt: got %0d exp 1", fetch_count); end
    tick();
    checks += 3;
    if (imemreq_addr !== 32'h208) begin errors++; $display("FAIL seq2_addr: got %h exp 00000208", imemreq_addr); end
    if (d2c_inst !== ~32'h204) begin errors++; $display("FAIL seq2_inst: got %h exp %h", d2c_inst, ~32'h204); end
    if (fetch_count !== 32'd2) begin errors++; $display("FAIL seq2_fcnt: got %0d exp 2", fetch_count); end
  endtask

  task automatic test_stall();
    reg_en_f = 0; reg_en_d = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks += 4;
      if (imemreq_addr !== 32'h208) begin errors++; $display("FAIL stall%0d_addr: got %h exp 00000208", i, imemreq_addr); end
      if (d2c_inst !== ~32'h204) begin errors++; $display("FAIL stall%0d_inst: got %h exp %h", i, d2c_inst, ~32'h204); end
      if (pc_d !== 32'h204) begin errors++; $display("FAIL stall%0d_pcd: got %h exp 00000204", i, pc_d); end
      if (fetch_count !== 32'd2) begin errors++; $display("FAIL stall%0d_fcnt: got %0d exp 2", i, fetch_count); end
    end
    reg_en_f = 1; reg_en_d = 1;
    tick();
    checks += 4;
    if (imemreq_addr !== 32'h20C) begin errors++; $display("FAIL rel_addr: got %h exp 0000020c", imemreq_addr); end
    if (d2c_inst !== ~32'h208) begin errors++; $display("FAIL rel_inst: got %h exp %h", d2c_inst, ~32'h208); end
    if (pc_d !== 32'h208) begin errors++; $display("FAIL rel_pcd: got %h exp 00000208", pc_d); end
    if (fetch_count !== 32'd3) begin errors++; $display("FAIL rel_fcnt: got %0d exp 3", fetch_count); end
    tick();
    checks += 3;
    if (imemreq_addr !== 32'h210) begin errors++; $display("FAIL rel2_addr: got %h exp 00000210", imemreq_addr); end
    if (d2c_inst !== ~32'h20C) begin errors++; $display("FAIL rel2_inst: got %h exp %h", d2c_inst, ~32'h20C); end
    if (fetch_count !== 32'd4) begin errors++; $display("FAIL rel2_fcnt: got %0d exp 4", fetch_count); end
  endtask

  task automatic test_branch();
    pc_sel = 3; br_t = 32'h300; squash = 1; reg_en_f = 0;
    tick();
    checks += 5;
    if (imemreq_addr !== 32'h300) begin errors++; $display("FAIL br_addr: got %h exp 00000300", imemreq_addr); end
    if (d2c_inst !== 32'h0) begin errors++; $display("FAIL br_inst: got %h exp 0", d2c_inst); end
    if (pc_d !== 32'h20C) begin errors++; $display("FAIL br_pcd: got %h exp 0000020c", pc_d); end
    if (squash_count !== 32'd1) begin errors++; $display("FAIL br_scnt: got %0d exp 1", squash_count); end
    if (fetch_count !== 32'd4) begin errors++; $display("FAIL br_fcnt: got %0d exp 4", fetch_count); end
    pc_sel = 0; squash = 0; reg_en_f = 1;
    tick();
    checks += 4;
    if (imemreq_addr !== 32'h304) begin errors++; $display("FAIL brn_addr: got %h exp 00000304", imemreq_addr); end
    if (d2c_inst !== ~32'h300) begin errors++; $display("FAIL brn_inst: got %h exp %h", d2c_inst, ~32'h300); end
    if (pc_d !== 32'h300) begin errors++; $display("FAIL brn_pcd: got %h exp 00000300", pc_d); end
    if (fetch_count !== 32'd5) begin errors++; $display("FAIL brn_fcnt: got %0d exp 5", fetch_count); end
  endtask

  task automatic test_squash();
    squash = 1;
    tick();
    checks += 4;
    if (d2c_inst !== 32'h0) begin errors++; $display("FAIL sq1_inst: got %h exp 0", d2c_inst); end
    if (pc_d !== 32'h300) begin errors++; $display("FAIL sq1_pcd: got %h exp 00000300", pc_d); end
    if (squash_count !== 32'd2) begin errors++; $display("FAIL sq1_scnt: got %0d exp 2", squash_count); end
    if (imemreq_addr !== 32'h308) begin errors++; $display("FAIL sq1_addr: got %h exp 00000308", imemreq_addr); end
    reg_en_d = 0;
    tick();
    checks += 3;
    if (d2c_inst !== 32'h0) begin errors++; $display("FAIL sq2_inst: got %h exp 0", d2c_inst); end
    if (squash_count !== 32'd2) begin errors++; $display("FAIL sq2_bubble_scnt: got %0d exp 2", squash_count); end
    if (imemreq_addr !== 32'h30C) begin errors++; $display("FAIL sq2_addr: got %h exp 0000030c", imemreq_addr); end
    squash = 0; reg_en_d = 1;
    tick();
    checks += 3;
    if (d2c_inst !== ~32'h30C) begin errors++; $display("FAIL sq3_inst: got %h exp %h", d2c_inst, ~32'h30C); end
    if (pc_d !== 32'h30C) begin errors++; $display("FAIL sq3_pcd: got %h exp 0000030c", pc_d); end
    if (fetch_count !== 32'd6) begin errors++; $display("FAIL sq3_fcnt: got %0d exp 6", fetch_count); end
  endtask

  task automatic test_jal();
    pc_sel = 1; jal_t = 32'h240;
    tick();
    checks += 4;
    if (imemreq_addr !== 32'h240) begin errors++; $display("FAIL jal_addr: got %h exp 00000240", imemreq_addr); end
    if (d2c_inst !== ~32'h310) begin errors++; $display("FAIL jal_inst: got %h exp %h", d2c_inst, ~32'h310); end
    if (pc_d !== 32'h310) begin errors++; $display("FAIL jal_pcd: got %h exp 00000310", pc_d); end
    if (fetch_count !== 32'd7) begin errors++; $display("FAIL jal_fcnt: got %0d exp 7", fetch_count); end
    pc_sel = 0;
    tick();
    checks += 2;
    if (imemreq_addr !== 32'h244) begin errors++; $display("FAIL jaln_addr: got %h exp 00000244", imemreq_addr); end
    if (d2c_inst !== ~32'h240) begin errors++; $display("FAIL jaln_inst: got %h exp %h", d2c_inst, ~32'h240); end
  endtask

  task automatic test_wrap();
    pc_sel = 2; jr_t = 32'hFFFF_FFFC;
    tick();
    checks += 2;
    if (imemreq_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL jr_addr: got %h exp fffffffc", imemreq_addr); end
    if (fetch_count !== 32'd9) begin errors++; $display("FAIL jr_fcnt: got %0d exp 9", fetch_count); end
    pc_sel = 0;
    tick();
    checks += 3;
    if (imemreq_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h exp 00000000", imemreq_addr); end
    if (d2c_inst !== 32'h3) begin errors++; $display("FAIL wrap_inst: got %h exp 00000003", d2c_inst); end
    if (pc_d !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pcd: got %h exp fffffffc", pc_d); end
    req_val = 0;
    #1;
    checks++;
    if (imemreq_val !== 1'b0) begin errors++; $display("FAIL noreq_val: got %b exp 0", imemreq_val); end
    tick();
    checks += 4;
    if (d2c_inst !== 32'h0) begin errors++; $display("FAIL noreq_inst: got %h exp 0", d2c_inst); end
    if (pc_d !== 32'h0) begin errors++; $display("FAIL noreq_pcd: got %h exp 0", pc_d); end
    if (fetch_count !== 32'd10) begin errors++; $display("FAIL noreq_fcnt: got %0d exp 10", fetch_count); end
    if (imemreq_addr !== 32'h4) begin errors++; $display("FAIL noreq_addr: got %h exp 00000004", imemreq_addr); end
    req_val = 1; mem_zero = 1;
    tick();
    checks += 3;
    if (d2c_inst !== 32'h0) begin errors++; $display("FAIL zdata_inst: got %h exp 0", d2c_inst); end
    if (pc_d !== 32'h4) begin errors++; $display("FAIL zdata_pcd: got %h exp 00000004", pc_d); end
    if (fetch_count !== 32'd10) begin errors++; $display("FAIL zdata_fcnt: got %0d exp 10", fetch_count); end
    mem_zero = 0;
  endtask

  task automatic test_reset_mid();
    squash = 1; pc_sel = 3; br_t = 32'h500; rst = 1;
    tick();
    checks += 6;
    if (imemreq_addr !== 32'h200) begin errors++; $display("FAIL mrst_addr: got %h exp 00000200", imemreq_addr); end
    if (imemreq_val !== 1'b0) begin errors++; $display("FAIL mrst_val: got %b exp 0", imemreq_val); end
    if (d2c_inst !== 32'h0) begin errors++; $display("FAIL mrst_inst: got %h exp 0", d2c_inst); end
    if (pc_d !== 32'h0) begin errors++; $display("FAIL mrst_pcd: got %h exp 0", pc_d); end
    if (fetch_count !== 32'd0) begin errors++; $display("FAIL mrst_fcnt: got %0d exp 0", fetch_count); end
    if (squash_count !== 32'd0) begin errors++; $display("FAIL mrst_scnt: got %0d exp 0", squash_count); end
    rst = 0; squash = 0; pc_sel = 0;
    tick();
    checks += 3;
    if (imemreq_addr !== 32'h204) begin errors++; $display("FAIL post_addr: got %h exp 00000204", imemreq_addr); end
    if (d2c_inst !== ~32'h200) begin errors++; $display("FAIL post_inst: got %h exp %h", d2c_inst, ~32'h200); end
    if (fetch_count !== 32'd1) begin errors++; $display("FAIL post_fcnt: got %0d exp 1", fetch_count); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_squash();
    test_jal();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
